// File: rtl/bram_arb2_pkg.sv
// bram_arb_pkg: shared types for the two-requester BRAM arbiter.
//   req_id_t     - requester identity, also used as the round-robin last pointer
//   ctrl_state_t - controller sequencing states
package bram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/bram_arb2_if.sv
// bram_arb2_if: all client-side and BRAM-side handshake signals of bram_arb2.
//   slave  - the arbiter's view (drives RDY/grants, dataOut, BRAM commands, initDone)
//   master - the environment's view (requesters plus the BRAM itself)
// Parameters: width (data bits), depth (BRAM entries, AW = $clog2(depth)).
interface bram_arb2_if #(
    parameter int width = 4,
    parameter int depth = 1024
);
    localparam int AW = $clog2(depth);

    // requester A
    logic             a_write__ENA, a_write__RDY;
    logic [AW-1:0]    a_write_addr;
    logic [width-1:0] a_write_data;
    logic             a_read__ENA, a_read__RDY;
    logic [AW-1:0]    a_read_addr;
    logic [width-1:0] a_dataOut;
    logic             a_dataOut__RDY;

    // requester B
    logic             b_write__ENA, b_write__RDY;
    logic [AW-1:0]    b_write_addr;
    logic [width-1:0] b_write_data;
    logic             b_read__ENA, b_read__RDY;
    logic [AW-1:0]    b_read_addr;
    logic [width-1:0] b_dataOut;
    logic             b_dataOut__RDY;

    // BRAM ports
    logic             mem_write__ENA, mem_write__RDY;
    logic [AW-1:0]    mem_write_addr;
    logic [width-1:0] mem_write_data;
    logic             mem_read__ENA, mem_read__RDY;
    logic [AW-1:0]    mem_read_addr;
    logic [width-1:0] mem_dataOut;
    logic             mem_dataOut__RDY;

    logic             initDone;

    modport slave (
        input  a_write__ENA, a_write_addr, a_write_data, a_read__ENA, a_read_addr,
        input  b_write__ENA, b_write_addr, b_write_data, b_read__ENA, b_read_addr,
        input  mem_write__RDY, mem_read__RDY, mem_dataOut, mem_dataOut__RDY,
        output a_write__RDY, a_read__RDY, a_dataOut, a_dataOut__RDY,
        output b_write__RDY, b_read__RDY, b_dataOut, b_dataOut__RDY,
        output mem_write__ENA, mem_write_addr, mem_write_data,
        output mem_read__ENA, mem_read_addr, initDone
    );

    modport master (
        output a_write__ENA, a_write_addr, a_write_data, a_read__ENA, a_read_addr,
        output b_write__ENA, b_write_addr, b_write_data, b_read__ENA, b_read_addr,
        output mem_write__RDY, mem_read__RDY, mem_dataOut, mem_dataOut__RDY,
        input  a_write__RDY, a_read__RDY, a_dataOut, a_dataOut__RDY,
        input  b_write__RDY, b_read__RDY, b_dataOut, b_dataOut__RDY,
        input  mem_write__ENA, mem_write_addr, mem_write_data,
        input  mem_read__ENA, mem_read_addr, initDone
    );

endinterface

// File: rtl/bram_arb2_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a last-winner pointer.
//   CLK, nRST - clock, synchronous active-low reset
//   en        - grant enable (port ready and controller running)
//   req[1:0]  - request per requester (bit 0 = A, bit 1 = B)
//   gnt[1:0]  - one-hot grant, combinational from req
//   gnt_id    - identity of the granted requester (A when nothing granted)
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            gnt_id
);

    req_id_t last;

    // Reset to B so that A wins the first contention.
    always_ff @(posedge CLK) begin
        if (!nRST)     last <= REQ_B;
        else if (|gnt) last <= gnt_id;
    end

    always_comb begin
        gnt = '0;
        if (en) begin
            if (&req) gnt = (last == REQ_B) ? 2'b01 : 2'b10;
            else      gnt = req;
        end
    end

    assign gnt_id = gnt[1] ? REQ_B : REQ_A;

endmodule

// File: rtl/bram_arb2.sv
// bram_arb2: arbiter/sequencer sharing one BRAM (independent 1-cycle-latency
// read port and write port) between requesters A and B.
//   CLK, nRST - clock, synchronous active-low reset
//   bus       - bram_arb2_if.slave: client write/read requests and grants,
//               per-client read data + one-cycle valid pulse, BRAM write/read
//               command ports, BRAM read data, initDone.
// Writes and reads are arbitrated independently, round-robin, so one write and
// one read can be granted in the same cycle. Read data is routed back to the
// issuing requester and held until its next response.
// Optional feature: define BRAM_ARB_CLEAR_EN to fill every entry with
// INIT_VALUE after reset before client traffic is accepted.
module bram_arb2
    import bram_arb_pkg::*;
#(
    parameter int               width      = 4,
    parameter int               depth      = 1024,
    parameter logic [width-1:0] INIT_VALUE = '0
) (
    input logic       CLK,
    input logic       nRST,
    bram_arb2_if.slave bus
);

    localparam int AW = $clog2(depth);

    ctrl_state_t state, state_nx;
    logic        run;
    logic [AW-1:0] clr_addr;
    logic        clr_last;

    logic [NUM_REQ-1:0]            wreq, wgnt, rreq, rgnt;
    logic [NUM_REQ-1:0][AW-1:0]    waddr, raddr;
    logic [NUM_REQ-1:0][width-1:0] wdata, dout;
    logic [NUM_REQ-1:0]            dout_rdy, rsp_lane;
    req_id_t                       wgnt_id, rgnt_id, rsp_id;
    logic                          wsel, rsel, rsp_valid;

    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [width-1:0] mem_wd;

    // ---------------- controller FSM ----------------
    always_ff @(posedge CLK) begin
        if (!nRST) state <= WAIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
`ifdef BRAM_ARB_CLEAR_EN
            WAIT:    state_nx = CLEAR;
`else
            WAIT:    state_nx = RUN;
`endif
            CLEAR:   if (clr_last) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = WAIT;
        endcase
    end

    // Write port owner: the clear sweep in CLEAR (ignores mem_write__RDY),
    // the granted requester in RUN, nobody otherwise.
    always_comb begin
        run    = 1'b0;
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_addr;
                mem_wd = INIT_VALUE;
            end
            RUN: begin
                run    = 1'b1;
                mem_we = |wgnt;
                mem_wa = waddr[wsel];
                mem_wd = wdata[wsel];
            end
            default: ;
        endcase
    end

`ifdef BRAM_ARB_CLEAR_EN
    // Sweep pointer; a reset mid-clear restarts the sweep from 0.
    always_ff @(posedge CLK) begin
        if (!nRST)               clr_addr <= '0;
        else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end
    assign clr_last = (clr_addr == AW'(depth - 1));
`else
    assign clr_addr = '0;
    assign clr_last = 1'b1;
`endif

    // ---------------- arbitration ----------------
    assign wreq  = {bus.b_write__ENA, bus.a_write__ENA};
    assign rreq  = {bus.b_read__ENA,  bus.a_read__ENA};
    assign waddr = {bus.b_write_addr, bus.a_write_addr};
    assign wdata = {bus.b_write_data, bus.a_write_data};
    assign raddr = {bus.b_read_addr,  bus.a_read_addr};

    rr_arb2 u_wr_arb (
        .CLK    (CLK),
        .nRST   (nRST),
        .en     (run && bus.mem_write__RDY),
        .req    (wreq),
        .gnt    (wgnt),
        .gnt_id (wgnt_id)
    );

    rr_arb2 u_rd_arb (
        .CLK    (CLK),
        .nRST   (nRST),
        .en     (run && bus.mem_read__RDY),
        .req    (rreq),
        .gnt    (rgnt),
        .gnt_id (rgnt_id)
    );

    assign wsel = (wgnt_id == REQ_B);
    assign rsel = (rgnt_id == REQ_B);

    assign bus.a_write__RDY = wgnt[0];
    assign bus.b_write__RDY = wgnt[1];
    assign bus.a_read__RDY  = rgnt[0];
    assign bus.b_read__RDY  = rgnt[1];

    assign bus.mem_write__ENA = mem_we;
    assign bus.mem_write_addr = mem_wa;
    assign bus.mem_write_data = mem_wd;
    assign bus.mem_read__ENA  = |rgnt;
    assign bus.mem_read_addr  = raddr[rsel];
    assign bus.initDone       = (state == RUN);

    // ---------------- response routing ----------------
    // Remember who owns the read in flight; the BRAM answers next cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rsp_valid <= 1'b0;
            rsp_id    <= REQ_A;
        end else begin
            rsp_valid <= |rgnt;
            rsp_id    <= rgnt_id;
        end
    end

    assign rsp_lane = !(rsp_valid && bus.mem_dataOut__RDY) ? 2'b00 :
                      (rsp_id == REQ_B) ? 2'b10 : 2'b01;

    // Reset has priority, so a response arriving during reset is dropped.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            dout     <= '0;
            dout_rdy <= '0;
        end else begin
            dout_rdy <= rsp_lane;
            for (int i = 0; i < NUM_REQ; i++)
                if (rsp_lane[i]) dout[i] <= bus.mem_dataOut;
        end
    end

    assign bus.a_dataOut      = dout[0];
    assign bus.b_dataOut      = dout[1];
    assign bus.a_dataOut__RDY = dout_rdy[0];
    assign bus.b_dataOut__RDY = dout_rdy[1];

endmodule

// File: tb/tb_bram_arb2.sv
// Self-checking bench for bram_arb2 (width 4, depth 16, INIT_VALUE 0xA).
// Table of directed vectors with constant expectations, a reset-during-read
// sequence, and randomized traffic checked against a queue-based reference
// model. Honors BRAM_ARB_CLEAR_EN when defined.
module tb_bram_arb2;

    localparam int W = 4;
    localparam int D = 16;
    localparam logic [3:0] INIT = 4'hA;
`ifdef BRAM_ARB_CLEAR_EN
    localparam logic [3:0] BOOT = 4'h5;
    localparam logic [3:0] MEM0 = INIT;
`else
    localparam logic [3:0] BOOT = 4'h0;
    localparam logic [3:0] MEM0 = 4'h0;
`endif

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    bram_arb2_if #(.width(W), .depth(D)) bus ();

    bram_arb2 #(.width(W), .depth(D), .INIT_VALUE(INIT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // ---------------- BRAM model: 1-cycle read, read-before-write ----------------
    logic [3:0] bram [D];
    bit mem_loaded;
    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < D; i++) bram[i] <= BOOT;
            mem_loaded <= 1'b1;
            bus.mem_dataOut__RDY <= 1'b0;
            bus.mem_dataOut <= '0;
        end else begin
            bus.mem_dataOut__RDY <= bus.mem_read__ENA;
            if (bus.mem_read__ENA) bus.mem_dataOut <= bram[bus.mem_read_addr];
            if (bus.mem_write__ENA) bram[bus.mem_write_addr] <= bus.mem_write_data;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        int         id;
        logic [3:0] data;
    } rsp_t;

    logic [3:0] ref_mem [D];
    logic [3:0] exp_out [2];
    rsp_t       rq [$];
    int         last_w, last_r;   // 0 = A, 1 = B
    bit         m_run;
    int         cyc;
    int         n_vec, n_err;

    function automatic int pick(input bit a, input bit b, input int last);
        if (a && b) return (last == 1) ? 0 : 1;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle();
        bus.a_write__ENA = 0; bus.b_write__ENA = 0;
        bus.a_read__ENA  = 0; bus.b_read__ENA  = 0;
        bus.a_write_addr = '0; bus.a_write_data = '0;
        bus.b_write_addr = '0; bus.b_write_data = '0;
        bus.a_read_addr  = '0; bus.b_read_addr  = '0;
        bus.mem_write__RDY = 1; bus.mem_read__RDY = 1;
    endtask

    // Check the current cycle against the model, then advance the model.
    task automatic sample_chk();
        int wg, rg;
        bit ea, eb;
        logic [3:0] wa, wd, ra;
        rsp_t r;
        @(negedge CLK);
        wg = (m_run && bus.mem_write__RDY) ? pick(bus.a_write__ENA, bus.b_write__ENA, last_w) : -1;
        rg = (m_run && bus.mem_read__RDY)  ? pick(bus.a_read__ENA,  bus.b_read__ENA,  last_r) : -1;
        wa = (wg == 1) ? bus.b_write_addr : bus.a_write_addr;
        wd = (wg == 1) ? bus.b_write_data : bus.a_write_data;
        ra = (rg == 1) ? bus.b_read_addr  : bus.a_read_addr;
        chk("initDone",       bus.initDone,       m_run);
        chk("a_write__RDY",   bus.a_write__RDY,   wg == 0);
        chk("b_write__RDY",   bus.b_write__RDY,   wg == 1);
        chk("a_read__RDY",    bus.a_read__RDY,    rg == 0);
        chk("b_read__RDY",    bus.b_read__RDY,    rg == 1);
        chk("mem_write__ENA", bus.mem_write__ENA, wg >= 0);
        chk("mem_read__ENA",  bus.mem_read__ENA,  rg >= 0);
        if (wg >= 0) begin
            chk("mem_write_addr", bus.mem_write_addr, wa);
            chk("mem_write_data", bus.mem_write_data, wd);
        end
        if (rg >= 0) chk("mem_read_addr", bus.mem_read_addr, ra);
        ea = 0; eb = 0;
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            if (r.id == 0) begin ea = 1; exp_out[0] = r.data; end
            else           begin eb = 1; exp_out[1] = r.data; end
        end
        chk("a_dataOut__RDY", bus.a_dataOut__RDY, ea);
        chk("b_dataOut__RDY", bus.b_dataOut__RDY, eb);
        chk("a_dataOut",      bus.a_dataOut,      exp_out[0]);
        chk("b_dataOut",      bus.b_dataOut,      exp_out[1]);
        if (rg >= 0) begin
            rq.push_back('{cyc + 2, rg, ref_mem[ra]});
            last_r = rg;
        end
        if (wg >= 0) begin
            ref_mem[wa] = wd;
            last_w = wg;
        end
    endtask

    task automatic do_reset();
        nRST = 0;
        idle();
        adv();
        // In reset: requests must be ignored and everything held at reset values.
        bus.a_write__ENA = 1; bus.b_write__ENA = 1;
        bus.a_read__ENA  = 1; bus.b_read__ENA  = 1;
        @(negedge CLK);
        chk("rst a_dataOut__RDY", bus.a_dataOut__RDY, 0);
        chk("rst b_dataOut__RDY", bus.b_dataOut__RDY, 0);
        chk("rst a_dataOut",      bus.a_dataOut,      0);
        chk("rst b_dataOut",      bus.b_dataOut,      0);
        chk("rst initDone",       bus.initDone,       0);
        chk("rst RDYs",           {bus.a_write__RDY, bus.b_write__RDY, bus.a_read__RDY, bus.b_read__RDY}, 0);
        chk("rst mem ENAs",       {bus.mem_write__ENA, bus.mem_read__ENA}, 0);
        adv();
        rq.delete();
        exp_out[0] = '0; exp_out[1] = '0;
        last_w = 1; last_r = 1;
        m_run = 0;
        nRST = 1;
        sample_chk();              // cycle 1 after release: WAIT, nothing granted
        adv();
`ifdef BRAM_ARB_CLEAR_EN
        bus.mem_write__RDY = 0;    // clear must not wait on the write port
        for (int i = 0; i < D; i++) begin
            @(negedge CLK);
            chk("clr initDone",       bus.initDone,       0);
            chk("clr mem_write__ENA", bus.mem_write__ENA, 1);
            chk("clr mem_write_addr", bus.mem_write_addr, i);
            chk("clr mem_write_data", bus.mem_write_data, INIT);
            chk("clr RDYs", {bus.a_write__RDY, bus.b_write__RDY, bus.a_read__RDY, bus.b_read__RDY}, 0);
            ref_mem[i] = INIT;
            adv();
        end
`endif
        idle();
        m_run = 1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit aw, bw; logic [3:0] awa, awd, bwa, bwd;
        bit ar, br; logic [3:0] ara, bra;
        bit wrdy, rrdy;
        bit e_awr, e_bwr, e_arr, e_brr, e_ap, e_bp;
        logic [3:0] e_ao, e_bo;
    } vec_t;

    vec_t tbl [14];

    task automatic set_row(input vec_t v);
        bus.a_write__ENA = v.aw; bus.b_write__ENA = v.bw;
        bus.a_write_addr = v.awa; bus.a_write_data = v.awd;
        bus.b_write_addr = v.bwa; bus.b_write_data = v.bwd;
        bus.a_read__ENA = v.ar; bus.b_read__ENA = v.br;
        bus.a_read_addr = v.ara; bus.b_read_addr = v.bra;
        bus.mem_write__RDY = v.wrdy; bus.mem_read__RDY = v.rrdy;
    endtask

    initial begin
        //           aw bw awa awd bwa bwd ar br ara bra wr rr | awr bwr arr brr ap bp ao bo
        tbl[0]  = '{1, 1, 5, 3, 5, 9, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 5, 3, 5, 9, 0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 7, 2, 0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 1, 1,   0, 0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 1, 1,   0, 0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 4, 0, 0, 0, 1, 0, 1, 1, 1,   1, 0, 0, 1, 1, 0, 9, 0};
        tbl[6]  = '{1, 0, 2, 6, 0, 0, 1, 0, 1, 0, 0, 1,   0, 0, 1, 0, 0, 1, 9, 2};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 9, MEM0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 4, MEM0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 5, 7, 1, 1,   0, 0, 0, 1, 0, 0, 4, MEM0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 5, 7, 1, 1,   0, 0, 1, 0, 0, 0, 4, MEM0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 4, 2};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 9, 2};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0,   0, 0, 0, 0, 0, 0, 9, 2};

        for (int i = 0; i < D; i++) ref_mem[i] = BOOT;
        cyc = 0; n_vec = 0; n_err = 0;
        idle();

        do_reset();

`ifdef BRAM_ARB_CLEAR_EN
        // Every entry must read back as INIT_VALUE after the clear.
        for (int i = 0; i < D + 2; i++) begin
            bus.a_read__ENA = (i < D);
            bus.a_read_addr = 4'(i);
            sample_chk();
            adv();
        end
        idle();
        do_reset();
`endif

        for (int i = 0; i < 14; i++) begin
            set_row(tbl[i]);
            sample_chk();
            chk($sformatf("tbl%0d a_write__RDY", i),   bus.a_write__RDY,   tbl[i].e_awr);
            chk($sformatf("tbl%0d b_write__RDY", i),   bus.b_write__RDY,   tbl[i].e_bwr);
            chk($sformatf("tbl%0d a_read__RDY", i),    bus.a_read__RDY,    tbl[i].e_arr);
            chk($sformatf("tbl%0d b_read__RDY", i),    bus.b_read__RDY,    tbl[i].e_brr);
            chk($sformatf("tbl%0d a_dataOut__RDY", i), bus.a_dataOut__RDY, tbl[i].e_ap);
            chk($sformatf("tbl%0d b_dataOut__RDY", i), bus.b_dataOut__RDY, tbl[i].e_bp);
            chk($sformatf("tbl%0d a_dataOut", i),      bus.a_dataOut,      tbl[i].e_ao);
            chk($sformatf("tbl%0d b_dataOut", i),      bus.b_dataOut,      tbl[i].e_bo);
            adv();
        end

        // Reset right after a read grant: the response must be dropped.
        idle();
        bus.a_read__ENA = 1;
        bus.a_read_addr = 4'd5;
        sample_chk();
        chk("rstmid a_read__RDY", bus.a_read__RDY, 1);
        adv();
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.a_write__ENA = 1'($urandom_range(0, 1));
            bus.b_write__ENA = 1'($urandom_range(0, 1));
            bus.a_read__ENA  = 1'($urandom_range(0, 1));
            bus.b_read__ENA  = 1'($urandom_range(0, 1));
            bus.a_write_addr = 4'($urandom_range(0, D - 1));
            bus.b_write_addr = 4'($urandom_range(0, D - 1));
            bus.a_write_data = 4'($urandom_range(0, 15));
            bus.b_write_data = 4'($urandom_range(0, 15));
            bus.a_read_addr  = 4'($urandom_range(0, D - 1));
            bus.b_read_addr  = 4'($urandom_range(0, D - 1));
            bus.mem_write__RDY = ($urandom_range(0, 4) != 0);
            bus.mem_read__RDY  = ($urandom_range(0, 4) != 0);
            sample_chk();
            adv();
        end

        idle();
        repeat (3) begin
            sample_chk();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
